// File: rtl/plm_pkg.sv
// Shared types and helpers for the private-local-memory buffer: swap FSM states,
// clog2 and field extraction from packed multi-port vectors.
package plm_pkg;

  localparam int MAX_PORTS   = 4;
  localparam int MAX_FIELD_W = 64;
  localparam int MAX_VEC_W   = MAX_PORTS * MAX_FIELD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2,
    WAIT  = 2'd3
  } swap_st_e;

  function automatic int clog2(input int unsigned value);
    int res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

  // Returns field idx of width w from a packed vector, zero-extended to MAX_FIELD_W.
  function automatic logic [MAX_FIELD_W-1:0] get_field(input logic [MAX_VEC_W-1:0] vec,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    logic [MAX_VEC_W-1:0]   tmp;
    logic [MAX_FIELD_W-1:0] mask;
    tmp  = vec >> (idx * w);
    mask = (w >= MAX_FIELD_W) ? '1 : ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
    return tmp[MAX_FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/plm_bank.sv
// One storage array with NUM_W masked write ports and NUM_R registered read-first ports.
// Same-address writes merge per bit (lowest port wins); conflict and range errors pulse next cycle.
module plm_bank
  import plm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int NUM_W  = 2,
  parameter int NUM_R  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_W-1:0]         wr_ce,
  input  logic [NUM_W-1:0]         wr_we,
  input  logic [NUM_W*ADDR_W-1:0]  wr_a,
  input  logic [NUM_W*DATA_W-1:0]  wr_d,
  input  logic [NUM_W*DATA_W-1:0]  wr_wem,
  input  logic [NUM_R-1:0]         rd_ce,
  input  logic [NUM_R*ADDR_W-1:0]  rd_a,
  output logic [NUM_R*DATA_W-1:0]  rd_q,
  output logic                     wr_conflict,
  output logic                     addr_err
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] wa   [NUM_W];
  logic [DATA_W-1:0] wd   [NUM_W];
  logic [DATA_W-1:0] wm   [NUM_W];
  logic [DATA_W-1:0] wval [NUM_W];
  logic [NUM_W-1:0]  wen, win, wok;
  logic [ADDR_W-1:0] ra   [NUM_R];
  logic [NUM_R-1:0]  rin;
  logic [DATA_W-1:0] rq_q [NUM_R];
  logic              conf_d, conf_q, err_d, err_q;

  for (genvar i = 0; i < NUM_W; i++) begin : g_wport
    assign wa[i]  = ADDR_W'(get_field(MAX_VEC_W'(wr_a), i, ADDR_W));
    assign wd[i]  = DATA_W'(get_field(MAX_VEC_W'(wr_d), i, DATA_W));
    assign wm[i]  = DATA_W'(get_field(MAX_VEC_W'(wr_wem), i, DATA_W));
    assign wen[i] = wr_ce[i] & wr_we[i];
    assign win[i] = int'(wa[i]) < DEPTH;
    assign wok[i] = wen[i] & win[i];
  end

  for (genvar j = 0; j < NUM_R; j++) begin : g_rport
    assign ra[j]  = ADDR_W'(get_field(MAX_VEC_W'(rd_a), j, ADDR_W));
    assign rin[j] = int'(ra[j]) < DEPTH;
    assign rd_q[j*DATA_W +: DATA_W] = rq_q[j];
  end

  // Every port hitting an address computes the same merged word; applying
  // higher ports first lets the lowest-index port own overlapping mask bits.
  always_comb begin
    for (int i = 0; i < NUM_W; i++) begin
      wval[i] = mem[wa[i]];
      for (int k = NUM_W - 1; k >= 0; k--) begin
        if (wok[k] && (wa[k] == wa[i])) wval[i] = (wval[i] & ~wm[k]) | (wd[k] & wm[k]);
      end
    end
  end

  always_comb begin
    conf_d = 1'b0;
    err_d  = 1'b0;
    for (int i = 0; i < NUM_W; i++) begin
      for (int k = i + 1; k < NUM_W; k++) begin
        if (wen[i] && wen[k] && (wa[i] == wa[k])) conf_d = 1'b1;
      end
      if (wen[i] && !win[i]) err_d = 1'b1;
    end
    for (int j = 0; j < NUM_R; j++) begin
      if (rd_ce[j] && !rin[j]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_W; i++) begin
      if (wok[i]) mem[wa[i]] <= wval[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_R; j++) rq_q[j] <= '0;
      conf_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_R; j++) begin
        if (rd_ce[j]) rq_q[j] <= rin[j] ? mem[ra[j]] : '0;
      end
      conf_q <= conf_d;
      err_q  <= err_d;
    end
  end

  assign wr_conflict = conf_q;
  assign addr_err    = err_q;

endmodule

// File: rtl/plm_multiport_bank.sv
// Multi-port PLM buffer: one bank, or two ping-pong banks steered by bank_sel.
// Writes go to bank[bank_sel], reads to the other; swap runs IDLE->DRAIN->SWAP->WAIT.
module plm_multiport_bank
  import plm_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 10,
  parameter int NUM_W    = 2,
  parameter int NUM_R    = 2,
  parameter int PINGPONG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_W-1:0]         wr_ce,
  input  logic [NUM_W-1:0]         wr_we,
  input  logic [NUM_W*ADDR_W-1:0]  wr_a,
  input  logic [NUM_W*DATA_W-1:0]  wr_d,
  input  logic [NUM_W*DATA_W-1:0]  wr_wem,
  input  logic [NUM_R-1:0]         rd_ce,
  input  logic [NUM_R*ADDR_W-1:0]  rd_a,
  output logic [NUM_R*DATA_W-1:0]  rd_q,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     bank_sel,
  output logic                     wr_conflict,
  output logic                     addr_err
);

  localparam int NB = (PINGPONG != 0) ? 2 : 1;

  logic                    cur_sel;
  logic [NUM_R*DATA_W-1:0] bank_q [NB];
  logic [NB-1:0]           bank_conf, bank_err;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic wsel, rsel;
    assign wsel = (NB == 1) || (cur_sel == 1'(b));
    assign rsel = (NB == 1) || (cur_sel != 1'(b));

    plm_bank #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_W(NUM_W), .NUM_R(NUM_R)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_ce      (wr_ce & {NUM_W{wsel}}),
      .wr_we      (wr_we),
      .wr_a       (wr_a),
      .wr_d       (wr_d),
      .wr_wem     (wr_wem),
      .rd_ce      (rd_ce & {NUM_R{rsel}}),
      .rd_a       (rd_a),
      .rd_q       (bank_q[b]),
      .wr_conflict(bank_conf[b]),
      .addr_err   (bank_err[b])
    );
  end

  if (PINGPONG != 0) begin : g_pp
    swap_st_e         st_q, st_d;
    logic             sel_q, sel_d;
    logic [NUM_R-1:0] src_q;

    // src_q remembers which bank last loaded each read register, so rd_q
    // holds across a swap until that port reads again.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= IDLE;
        sel_q <= 1'b0;
        src_q <= '0;
      end else begin
        st_q  <= st_d;
        sel_q <= sel_d;
        for (int j = 0; j < NUM_R; j++) begin
          if (rd_ce[j]) src_q[j] <= ~sel_q;
        end
      end
    end

    always_comb begin
      st_d  = st_q;
      sel_d = sel_q;
      case (st_q)
        IDLE:    if (swap_req) st_d = DRAIN;
        DRAIN:   st_d = SWAP;
        SWAP: begin
          sel_d = ~sel_q;
          st_d  = WAIT;
        end
        WAIT:    if (!swap_req) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end

    assign cur_sel  = sel_q;
    assign swap_ack = (st_q == SWAP);

    for (genvar j = 0; j < NUM_R; j++) begin : g_rmux
      assign rd_q[j*DATA_W +: DATA_W] = src_q[j] ? bank_q[1][j*DATA_W +: DATA_W]
                                                 : bank_q[0][j*DATA_W +: DATA_W];
    end
  end else begin : g_single
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign cur_sel  = 1'b0;
    assign swap_ack = 1'b0;
    assign rd_q     = bank_q[0];
  end

  assign bank_sel    = cur_sel;
  assign wr_conflict = |bank_conf;
  assign addr_err    = |bank_err;

endmodule

// File: tb/tb_plm_multiport_bank.sv
// Directed bench: a single-bank instance (DEPTH=1000) and a ping-pong instance (DEPTH=1024).
module tb_plm_multiport_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  s_wr_ce, s_wr_we, s_rd_ce;
  logic [19:0] s_wr_a, s_rd_a;
  logic [15:0] s_wr_d, s_wr_wem, s_rd_q;
  logic        s_swap_req, s_swap_ack, s_bank_sel, s_conf, s_err;

  logic [1:0]  p_wr_ce, p_wr_we, p_rd_ce;
  logic [19:0] p_wr_a, p_rd_a;
  logic [15:0] p_wr_d, p_wr_wem, p_rd_q;
  logic        p_swap_req, p_swap_ack, p_bank_sel, p_conf, p_err;

  int n_cmp = 0;
  int n_bad = 0;
  int acks;

  plm_multiport_bank #(
    .DATA_W(8), .DEPTH(1000), .ADDR_W(10), .NUM_W(2), .NUM_R(2), .PINGPONG(0)
  ) u_sp (
    .clk(clk), .rst(rst),
    .wr_ce(s_wr_ce), .wr_we(s_wr_we), .wr_a(s_wr_a), .wr_d(s_wr_d), .wr_wem(s_wr_wem),
    .rd_ce(s_rd_ce), .rd_a(s_rd_a), .rd_q(s_rd_q),
    .swap_req(s_swap_req), .swap_ack(s_swap_ack), .bank_sel(s_bank_sel),
    .wr_conflict(s_conf), .addr_err(s_err)
  );

  plm_multiport_bank #(
    .DATA_W(8), .DEPTH(1024), .ADDR_W(10), .NUM_W(2), .NUM_R(2), .PINGPONG(1)
  ) u_pp (
    .clk(clk), .rst(rst),
    .wr_ce(p_wr_ce), .wr_we(p_wr_we), .wr_a(p_wr_a), .wr_d(p_wr_d), .wr_wem(p_wr_wem),
    .rd_ce(p_rd_ce), .rd_a(p_rd_a), .rd_q(p_rd_q),
    .swap_req(p_swap_req), .swap_ack(p_swap_ack), .bank_sel(p_bank_sel),
    .wr_conflict(p_conf), .addr_err(p_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_wr_ce = '0; s_wr_we = '0; s_wr_a = '0; s_wr_d = '0; s_wr_wem = '0;
    s_rd_ce = '0; s_rd_a = '0; s_swap_req = 1'b0;
    p_wr_ce = '0; p_wr_we = '0; p_wr_a = '0; p_wr_d = '0; p_wr_wem = '0;
    p_rd_ce = '0; p_rd_a = '0;
  endtask

  task automatic s_wr(input int p, input logic [9:0] a, input logic [7:0] d, input logic [7:0] m);
    s_wr_ce[p] = 1'b1;
    s_wr_we[p] = 1'b1;
    s_wr_a[p*10 +: 10] = a;
    s_wr_d[p*8 +: 8]   = d;
    s_wr_wem[p*8 +: 8] = m;
  endtask

  task automatic s_rd(input int p, input logic [9:0] a);
    s_rd_ce[p] = 1'b1;
    s_rd_a[p*10 +: 10] = a;
  endtask

  task automatic p_wr(input logic [9:0] a, input logic [7:0] d);
    p_wr_ce[0] = 1'b1;
    p_wr_we[0] = 1'b1;
    p_wr_a[9:0] = a;
    p_wr_d[7:0] = d;
    p_wr_wem[7:0] = 8'hFF;
  endtask

  task automatic p_rd(input logic [9:0] a);
    p_rd_ce[0] = 1'b1;
    p_rd_a[9:0] = a;
  endtask

  initial begin
    idle_all();
    p_swap_req = 1'b0;
    tick();
    tick();
    chk("rst_s_rd_q", 32'(s_rd_q), 32'h0);
    chk("rst_s_conf", 32'(s_conf), 32'h0);
    chk("rst_s_err", 32'(s_err), 32'h0);
    chk("rst_p_rd_q", 32'(p_rd_q), 32'h0);
    chk("rst_p_ack", 32'(p_swap_ack), 32'h0);
    chk("rst_p_bank_sel", 32'(p_bank_sel), 32'h0);
    rst = 1'b0;

    // Basic write then read on the other port
    s_wr(0, 10'd3, 8'hA5, 8'hFF);
    tick();
    idle_all();
    s_rd(1, 10'd3);
    tick();
    chk("rd1_addr3", 32'(s_rd_q[15:8]), 32'hA5);
    chk("rd0_untouched", 32'(s_rd_q[7:0]), 32'h0);

    // Disjoint masks on one address merge; conflict still flagged
    idle_all();
    s_wr(0, 10'd7, 8'h00, 8'hFF);
    tick();
    chk("single_wr_no_conf", 32'(s_conf), 32'h0);
    idle_all();
    s_wr(0, 10'd7, 8'hF0, 8'hF0);
    s_wr(1, 10'd7, 8'h0F, 8'h0F);
    tick();
    chk("merge_conf_pulse", 32'(s_conf), 32'h1);
    idle_all();
    s_rd(0, 10'd7);
    tick();
    chk("merge_addr7", 32'(s_rd_q[7:0]), 32'hFF);
    chk("merge_conf_clear", 32'(s_conf), 32'h0);

    // Overlapping masks: port 0 wins
    idle_all();
    s_wr(0, 10'd5, 8'h11, 8'hFF);
    s_wr(1, 10'd5, 8'h22, 8'hFF);
    tick();
    chk("overlap_conf", 32'(s_conf), 32'h1);
    idle_all();
    s_rd(1, 10'd5);
    tick();
    chk("overlap_addr5", 32'(s_rd_q[15:8]), 32'h11);

    // Read-first on same-cycle read/write
    idle_all();
    s_wr(0, 10'd9, 8'h33, 8'hFF);
    tick();
    idle_all();
    s_wr(0, 10'd9, 8'h44, 8'hFF);
    s_rd(0, 10'd9);
    tick();
    chk("rdw_old", 32'(s_rd_q[7:0]), 32'h33);
    idle_all();
    s_rd(0, 10'd9);
    tick();
    chk("rdw_new", 32'(s_rd_q[7:0]), 32'h44);
    idle_all();
    tick();
    chk("rd_hold", 32'(s_rd_q[7:0]), 32'h44);

    // Range boundary: DEPTH-1 is valid, DEPTH is dropped
    idle_all();
    s_wr(0, 10'd999, 8'h5C, 8'hFF);
    tick();
    chk("wr999_no_err", 32'(s_err), 32'h0);
    idle_all();
    s_wr(0, 10'd1000, 8'h77, 8'hFF);
    s_wr(1, 10'd4, 8'h66, 8'hFF);
    tick();
    chk("wr1000_err", 32'(s_err), 32'h1);
    chk("wr1000_no_conf", 32'(s_conf), 32'h0);
    idle_all();
    s_rd(0, 10'd4);
    s_rd(1, 10'd999);
    tick();
    chk("err_clear", 32'(s_err), 32'h0);
    chk("other_port_wrote", 32'(s_rd_q[7:0]), 32'h66);
    chk("rd999", 32'(s_rd_q[15:8]), 32'h5C);
    idle_all();
    s_rd(0, 10'd1005);
    tick();
    chk("rd1005_zero", 32'(s_rd_q[7:0]), 32'h0);
    chk("rd1005_err", 32'(s_err), 32'h1);
    chk("sp_bank_sel", 32'(s_bank_sel), 32'h0);
    chk("sp_ack", 32'(s_swap_ack), 32'h0);

    // Ping-pong: fill bank 0, swap, read it back
    idle_all();
    p_wr(10'd0, 8'h5A);
    tick();
    idle_all();
    p_swap_req = 1'b1;
    tick();
    chk("pp_drain_no_ack", 32'(p_swap_ack), 32'h0);
    p_swap_req = 1'b0;
    tick();
    chk("pp_ack", 32'(p_swap_ack), 32'h1);
    chk("pp_sel_pre", 32'(p_bank_sel), 32'h0);
    tick();
    chk("pp_ack_done", 32'(p_swap_ack), 32'h0);
    chk("pp_sel_post", 32'(p_bank_sel), 32'h1);
    p_rd(10'd0);
    tick();
    chk("pp_rd_bank0", 32'(p_rd_q[7:0]), 32'h5A);
    idle_all();
    p_wr(10'd1, 8'h3C);
    tick();
    idle_all();

    // Reset during DRAIN abandons the swap but keeps contents
    p_swap_req = 1'b1;
    tick();
    chk("pp_drain2_sel", 32'(p_bank_sel), 32'h1);
    rst = 1'b1;
    p_swap_req = 1'b0;
    tick();
    chk("pp_rst_sel", 32'(p_bank_sel), 32'h0);
    chk("pp_rst_ack", 32'(p_swap_ack), 32'h0);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (p_swap_ack) acks++;
    end
    chk("pp_rst_no_ack", 32'(acks), 32'h0);
    p_rd(10'd1);
    tick();
    chk("pp_retained_bank1", 32'(p_rd_q[7:0]), 32'h3C);
    idle_all();

    // Held request yields a single swap
    p_swap_req = 1'b1;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (p_swap_ack) acks++;
    end
    p_swap_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (p_swap_ack) acks++;
    end
    chk("pp_hold_one_ack", 32'(acks), 32'h1);
    chk("pp_hold_sel", 32'(p_bank_sel), 32'h1);
    p_rd(10'd0);
    tick();
    chk("pp_hold_rd_bank0", 32'(p_rd_q[7:0]), 32'h5A);
    idle_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
